// File: rtl/param_seq_alu_pkg.sv
// Shared encodings for the multi-cycle ALU: operation codes and FSM states.
// No ports. Used by param_seq_alu (top) and the testbench.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // S_ALU is the single execute cycle used by ADD/SUB (and DIV when the divider is absent).
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ALU  = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/param_seq_alu_if.sv
// Request/result handshake bundle for param_seq_alu.
//  master: requester side (drives in_valid/op/a/b/out_ready)
//  slave : ALU side (drives in_ready/out_valid/res_lo/res_hi/flag_c/flag_z/err)
interface param_seq_alu_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             flag_c;
  logic             flag_z;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, res_lo, res_hi, flag_c, flag_z, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, res_lo, res_hi, flag_c, flag_z, err
  );

endinterface

// File: rtl/param_seq_alu_div.sv
// seq_div_core: unsigned restoring divider, one quotient bit per cycle, WIDTH cycles.
// Ports: clk, rst (async active-low), start (load operands, ignored while busy),
//        dividend, divisor, busy (iterating), done (1-cycle pulse, result valid),
//        quot, rem. Divisor 0 naturally yields quot = all ones, rem = dividend.
module seq_div_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   trial;
  logic             fits;

  // Partial remainder with the next dividend bit shifted in, compared against the divisor.
  always_comb begin
    trial = {rem, quot[WIDTH-1]};
    fits  = (trial >= {1'b0, dvsr});
  end

  // Iteration registers; quot doubles as the dividend shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvsr <= '0;
      cnt  <= '0;
      quot <= '0;
      rem  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start && !busy) begin
      dvsr <= divisor;
      cnt  <= '0;
      quot <= dividend;
      rem  <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        rem  <= fits ? WIDTH'(trial - {1'b0, dvsr}) : trial[WIDTH-1:0];
        quot <= {quot[WIDTH-2:0], fits};
        cnt  <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/param_seq_alu.sv
// param_seq_alu: multi-cycle ALU (ADD, SUB, signed radix-4 Booth MUL, unsigned DIV),
// one operation in flight, valid/ready handshake on request and result sides.
// Ports: clk, rst (async active-low), bus (param_seq_alu_if.slave: in_valid/in_ready/op/a/b,
//        out_valid/out_ready/res_lo/res_hi/flag_c/flag_z/err).
// Build option: define ALU_DIV_EN to include the divider (seq_div_core); without it,
//        DIV completes in one cycle with zero result and err=1.
module param_seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  param_seq_alu_if.slave    bus
);

  localparam int unsigned HW = WIDTH + 2;        // Booth accumulator holds +/-2*multiplicand
  localparam int unsigned PW = 2 * WIDTH + 3;    // {accumulator, multiplier, q(-1)}
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_e state, state_nx;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;

  logic [HW-1:0]    mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_qm1;
  logic [CW-1:0]    mul_cnt;

  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;
  logic             flag_c_q, flag_z_q, err_q;

  logic             accept, load, step;
  logic [WIDTH-1:0] res_lo_nx, res_hi_nx;
  logic             flag_c_nx, err_nx;

  logic [HW-1:0]    m_ext, addend, booth_sum;
  logic [PW-1:0]    booth_shr;
  logic [WIDTH:0]   add_res;
  logic [WIDTH-1:0] sub_res;

  assign accept = bus.in_valid && in_ready_q;

  // One radix-4 Booth digit: add 0/+-M/+-2M to the accumulator, then shift the pair right by 2.
  always_comb begin
    m_ext  = {{2{a_q[WIDTH-1]}}, a_q};
    addend = '0;
    case ({mul_lo[1:0], mul_qm1})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = {m_ext[HW-2:0], 1'b0};
      3'b100:         addend = HW'(0) - {m_ext[HW-2:0], 1'b0};
      3'b101, 3'b110: addend = HW'(0) - m_ext;
      default:        addend = '0;
    endcase
    booth_sum = mul_hi + addend;
    booth_shr = {{2{booth_sum[HW-1]}}, booth_sum, mul_lo[WIDTH-1:1]};
  end

  // Single-cycle add/subtract on the registered operands.
  always_comb begin
    add_res = {1'b0, a_q} + {1'b0, b_q};
    sub_res = a_q - b_q;
  end

`ifdef ALU_DIV_EN
  logic             div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_quot, div_rem;

  assign div_start = accept && (bus.op == OP_DIV);

  seq_div_core #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (bus.a),
    .divisor  (bus.b),
    .busy     (div_busy),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next state and result selection; results are only loaded on entry to S_DONE.
  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    step      = 1'b0;
    res_lo_nx = res_lo_q;
    res_hi_nx = res_hi_q;
    flag_c_nx = flag_c_q;
    err_nx    = err_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (bus.op)
            OP_MUL:  state_nx = S_MUL;
`ifdef ALU_DIV_EN
            OP_DIV:  state_nx = S_DIV;
`endif
            default: state_nx = S_ALU;
          endcase
        end
      end
      S_ALU: begin
        state_nx  = S_DONE;
        load      = 1'b1;
        res_hi_nx = '0;
        flag_c_nx = 1'b0;
        err_nx    = 1'b0;
        case (op_q)
          OP_ADD:  {flag_c_nx, res_lo_nx} = add_res;
          OP_SUB: begin
            res_lo_nx = sub_res;
            flag_c_nx = (a_q < b_q);
          end
          default: begin
            // Only DIV without the divider reaches here.
            res_lo_nx = '0;
            err_nx    = 1'b1;
          end
        endcase
      end
      S_MUL: begin
        if (mul_cnt == CW'(WIDTH / 2)) begin
          state_nx               = S_DONE;
          load                   = 1'b1;
          {res_hi_nx, res_lo_nx} = {mul_hi[WIDTH-1:0], mul_lo};
          flag_c_nx              = 1'b0;
          err_nx                 = 1'b0;
        end else begin
          step = 1'b1;
        end
      end
      S_DIV: begin
`ifdef ALU_DIV_EN
        if (div_done) begin
          state_nx  = S_DONE;
          load      = 1'b1;
          res_lo_nx = div_quot;
          res_hi_nx = div_rem;
          flag_c_nx = 1'b0;
          err_nx    = (b_q == '0);
        end else if (!div_busy) begin
          // Core idle without a result: abandon rather than hang.
          state_nx = S_IDLE;
        end
`else
        state_nx = S_IDLE;
`endif
      end
      S_DONE: begin
        if (bus.out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand capture, Booth iteration and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mul_hi      <= '0;
      mul_lo      <= '0;
      mul_qm1     <= 1'b0;
      mul_cnt     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= bus.op;
        a_q     <= bus.a;
        b_q     <= bus.b;
        mul_hi  <= '0;
        mul_lo  <= bus.b;
        mul_qm1 <= 1'b0;
        mul_cnt <= '0;
      end else if (step) begin
        mul_hi  <= booth_shr[PW-1:WIDTH+1];
        mul_lo  <= booth_shr[WIDTH:1];
        mul_qm1 <= booth_shr[0];
        mul_cnt <= mul_cnt + CW'(1);
      end
      in_ready_q  <= (state_nx == S_IDLE);
      out_valid_q <= (state_nx == S_DONE);
      if (load) begin
        res_lo_q <= res_lo_nx;
        res_hi_q <= res_hi_nx;
        flag_c_q <= flag_c_nx;
        flag_z_q <= ({res_hi_nx, res_lo_nx} == '0);
        err_q    <= err_nx;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.res_lo    = res_lo_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_param_seq_alu.sv
// Self-checking bench for param_seq_alu (WIDTH=8): expected results are queued on issue
// and compared when the ALU presents a result. Honours ALU_DIV_EN like the design.
module tb_param_seq_alu;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         e;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  param_seq_alu_if #(.WIDTH(W)) bus ();

  param_seq_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t                  r;
    logic [W:0]            s;
    logic signed [2*W-1:0] p;
    r.lo = '0; r.hi = '0; r.c = 1'b0; r.e = 1'b0; r.lat = 1;
    case (op)
      OP_ADD: begin
        s    = {1'b0, a} + {1'b0, b};
        r.lo = s[W-1:0];
        r.c  = s[W];
      end
      OP_SUB: begin
        r.lo = a - b;
        r.c  = (a < b);
      end
      OP_MUL: begin
        p             = $signed(a) * $signed(b);
        {r.hi, r.lo}  = p;
        r.lat         = W / 2 + 1;
      end
      default: begin
`ifdef ALU_DIV_EN
        if (b == '0) begin
          r.lo = '1;
          r.hi = a;
          r.e  = 1'b1;
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
        r.lat = W + 1;
`else
        r.e = 1'b1;
`endif
      end
    endcase
    r.z = ({r.hi, r.lo} == '0);
    return r;
  endfunction

  // Issue one op, wait for its result, optionally hold out_ready low for `stall` cycles.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int stall);
    exp_t e;
    int   lat;
    int   guard;
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_at_issue", 32'(bus.in_ready), 32'd1);
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      if (stall > 0) begin
        bus.in_valid = 1'b1;
        bus.op       = 2'($urandom);
        bus.a        = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    e = sb.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("res_lo", 32'(bus.res_lo), 32'(e.lo));
    check("res_hi", 32'(bus.res_hi), 32'(e.hi));
    check("flag_c", 32'(bus.flag_c), 32'(e.c));
    check("flag_z", 32'(bus.flag_z), 32'(e.z));
    check("err", 32'(bus.err), 32'(e.e));
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.op       = OP_ADD;
      bus.a        = W'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_res", 32'({bus.res_hi, bus.res_lo}), 32'({e.hi, e.lo}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_back", 32'(bus.in_ready), 32'd1);
    check("idle_keeps_res", 32'({bus.res_hi, bus.res_lo}), 32'({e.hi, e.lo}));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_res", 32'({bus.res_hi, bus.res_lo}), 32'd0);
    check("rst_flags", 32'({bus.flag_c, bus.flag_z, bus.err}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op(OP_ADD, 8'd200, 8'd100, 0);
    do_op(OP_SUB, 8'd100, 8'd24, 0);
    do_op(OP_SUB, 8'd24, 8'd100, 0);
    do_op(OP_SUB, 8'd55, 8'd55, 0);
    do_op(OP_ADD, 8'd255, 8'd1, 0);
    do_op(OP_MUL, 8'd100, 8'd24, 0);
    do_op(OP_MUL, 8'hFD, 8'd5, 0);
    do_op(OP_MUL, 8'h80, 8'h80, 0);
    do_op(OP_MUL, 8'd0, 8'h9A, 0);
    do_op(OP_DIV, 8'd12, 8'd10, 0);
    do_op(OP_DIV, 8'd77, 8'd0, 0);
    do_op(OP_MUL, 8'h7F, 8'h81, 4);
    do_op(OP_DIV, 8'd200, 8'd7, 3);

    // Reset two cycles into a multiply: result discarded, handshake back to idle at once.
    @(negedge clk);
    bus.op        = OP_MUL;
    bus.a         = 8'd9;
    bus.b         = 8'd11;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_res", 32'({bus.res_hi, bus.res_lo}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_pulse", 32'(bus.out_valid), 32'd0);
    do_op(OP_ADD, 8'd1, 8'd1, 0);

    for (int i = 0; i < 20; i++) begin
      do_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom_range(0, 255)), 0);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
